// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_BLANK  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        BLANK  = ST_BLANK
    } state_t;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Holds at zero instead of wrapping; only a reload restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered digits.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to suppress leading-zero digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          scan_done
);
    // state  | meaning
    // IDLE   | display off, waiting for enable
    // ACTIVE | digit idx driven for TICK_DIV cycles
    // BLANK  | all digits off for BLANK_CYCLES cycles (ghosting gap)

    localparam int MAX_CNT = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int TW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int DW      = DIGIT_W * NUM_DIGITS;

    localparam logic [TW-1:0] ACTIVE_LOAD = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LOAD  = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_DIGITS - 1);

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DW-1:0]         pend_digits, act_digits, act_digits_nxt;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp, act_dp_nxt;
    logic                  pend_valid;
    logic                  swap, advance, frame_end;
    logic                  tmr_load, tmr_tc;
    logic [TW-1:0]         tmr_value;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic [DIGIT_W-1:0]    code_nxt;
    logic                  dp_nxt;

    seg_scan_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .tc         (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        swap      = 1'b0;
        advance   = 1'b0;
        frame_end = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ACTIVE;
                    idx_nxt   = '0;
                    swap      = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_value = ACTIVE_LOAD;
                end
                ACTIVE: begin
                    if (tmr_tc) begin
                        if (BLANK_CYCLES > 0) begin
                            state_nxt = BLANK;
                            tmr_load  = 1'b1;
                            tmr_value = BLANK_LOAD;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (tmr_tc) advance = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
            if (advance) begin
                state_nxt = ACTIVE;
                tmr_load  = 1'b1;
                tmr_value = ACTIVE_LOAD;
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    swap      = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
        end
    end

    // The swap consumes the pending value from before this edge; a coincident load lands in pending.
    always_comb begin
        act_digits_nxt = act_digits;
        act_dp_nxt     = act_dp;
        if (swap && pend_valid) begin
            act_digits_nxt = pend_digits;
            act_dp_nxt     = pend_dp;
        end
    end

    always_comb begin
        lz_mask = '0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above && (act_digits_nxt[DIGIT_W*i +: DIGIT_W] == '0);
                lz_mask[i] = zero_above;
            end
        end
`endif
    end

    always_comb begin
        sel_nxt  = '0;
        code_nxt = digit_code;
        dp_nxt   = dp_out;
        case (state_nxt)
            ACTIVE: begin
                code_nxt = act_digits_nxt[DIGIT_W*idx_nxt +: DIGIT_W];
                dp_nxt   = act_dp_nxt[idx_nxt];
                if (!lz_mask[idx_nxt]) sel_nxt = NUM_DIGITS'(onehot(3'(idx_nxt)));
            end
            BLANK: begin
                sel_nxt = '0;
            end
            default: begin
                code_nxt = '0;
                dp_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            digit_code  <= '0;
            dp_out      <= 1'b0;
            digit_sel   <= '0;
            scan_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            act_digits <= act_digits_nxt;
            act_dp     <= act_dp_nxt;
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end else if (swap) begin
                pend_valid <= 1'b0;
            end
            digit_code <= code_nxt;
            dp_out     <= dp_nxt;
            digit_sel  <= sel_nxt;
            scan_done  <= frame_end;
        end
    end

endmodule
